// File: rtl/line_fill_responder.sv
// Cache line-fill responder: waits LATENCY cycles, reads four words from a local
// backing store, returns them as one 128-bit line. Optional macro: LINE_FILL_RANGE_CHECK_EN.
module line_fill_responder #(
    parameter int MEM_DEPTH = 4096,
    parameter int LATENCY   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_req,
    input  logic [31:0]  mem_addr,
    output logic [127:0] mem_data_out,
    output logic         mem_ready,
    output logic         mem_err,
    input  logic         wr_en,
    input  logic [31:0]  wr_addr,
    input  logic [31:0]  wr_data
);

    localparam int         AW       = $clog2(MEM_DEPTH);
    localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [2:0] {IDLE, WAIT, FETCH, RESP, HOLD} state_t;

    state_t        state, state_next;
    logic [27:0]   line;
    logic [3:0]    wait_cnt;
    logic [1:0]    beat;
    logic [127:0]  line_buf;
    logic [31:0]   mem [MEM_DEPTH];
    logic [29:0]   rd_word_addr;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic          range_err;

    assign rd_word_addr = {line, beat};
    assign rd_idx       = rd_word_addr[AW-1:0];

    logic unused_bits;
    assign unused_bits = ^{mem_addr[3:0], wr_addr[31:AW], rd_word_addr[29:AW]};

    // NOTE: the backing store has no reset; its contents survive rst by design,
    // and leaving it out of the reset tree lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr[AW-1:0]] <= wr_data;
    end

`ifdef LINE_FILL_RANGE_CHECK_EN
    // Out-of-range lines never touch the array and return zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            range_err <= 1'b0;
        else if (state == IDLE && mem_req)
            range_err <= ({2'b00, mem_addr[31:4], 2'b00} >= 32'(MEM_DEPTH));
    end
    assign rd_word = range_err ? 32'd0 : mem[rd_idx];
`else
    assign range_err = 1'b0;
    assign rd_word   = mem[rd_idx];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: combinational blocks use blocking '=' with a default assigned first,
    // so every path drives every output and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mem_req) state_next = (LATENCY == 0) ? FETCH : WAIT;
            WAIT:    if (!mem_req) state_next = IDLE;
                     else if (wait_cnt == 4'd0) state_next = FETCH;
            FETCH:   if (!mem_req) state_next = IDLE;
                     else if (beat == 2'd3) state_next = RESP;
            RESP:    state_next = HOLD;
            HOLD:    if (!mem_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values; this also gives read-before-write against the array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line     <= '0;
            wait_cnt <= '0;
            beat     <= '0;
            line_buf <= '0;
        end else begin
            case (state)
                IDLE: if (mem_req) begin
                    line     <= mem_addr[31:4];
                    wait_cnt <= LAT_LOAD;
                    beat     <= 2'd0;
                end
                WAIT: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                FETCH: begin
                    line_buf[32*beat +: 32] <= rd_word;
                    beat                    <= beat + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_ready    = (state == RESP);
        mem_data_out = (state == RESP) ? line_buf : '0;
        mem_err      = (state == RESP) && range_err;
    end

endmodule

// File: tb/tb_line_fill_responder.sv
// Bench for line_fill_responder: two instances (LATENCY=3 and LATENCY=0) share the
// write port; responses are compared against a word-array model of the backing store.
module tb_line_fill_responder;

    localparam int DEPTH = 4096;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_en = 1'b0;
    logic [31:0]  wr_addr = '0;
    logic [31:0]  wr_data = '0;
    logic         req_a = 1'b0, req_b = 1'b0;
    logic [31:0]  addr_a = '0, addr_b = '0;
    logic [127:0] data_a, data_b;
    logic         ready_a, ready_b, err_a, err_b;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    line_fill_responder #(.MEM_DEPTH(DEPTH), .LATENCY(3)) dut_a (
        .clk(clk), .rst(rst), .mem_req(req_a), .mem_addr(addr_a),
        .mem_data_out(data_a), .mem_ready(ready_a), .mem_err(err_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    line_fill_responder #(.MEM_DEPTH(DEPTH), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .mem_req(req_b), .mem_addr(addr_b),
        .mem_data_out(data_b), .mem_ready(ready_b), .mem_err(err_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    function automatic logic model_err(input logic [31:0] addr);
`ifdef LINE_FILL_RANGE_CHECK_EN
        return ({2'b00, addr[31:4], 2'b00} >= 32'(DEPTH));
`else
        return 1'b0;
`endif
    endfunction

    // Line = the four words of the 16-byte block, each index wrapped to the store size.
    function automatic logic [127:0] model_line(input logic [31:0] addr);
        logic [127:0] r;
        int base;
        r = '0;
        if (model_err(addr)) return r;
        base = int'(addr >> 2) & ~3;
        for (int b = 0; b < 4; b++) r[32*b +: 32] = model_mem[(base + b) % DEPTH];
        return r;
    endfunction

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model_mem[a % DEPTH] = d;
    endtask

    // Raise a request at a negedge; lat = edges from accept to first mem_ready (-1 on timeout).
    task automatic do_req(input bit which, input logic [31:0] addr, input bit scramble,
                          output int lat, output logic [127:0] data, output logic err,
                          output logic rdy_after);
        logic rdy;
        @(negedge clk);
        if (which) begin req_b = 1'b1; addr_b = addr; end
        else       begin req_a = 1'b1; addr_a = addr; end
        @(posedge clk);
        lat = -1; data = '0; err = 1'b0; rdy_after = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (scramble) begin
                @(negedge clk);
                if (which) addr_b = $urandom; else addr_a = $urandom;
            end
            @(posedge clk); #1;
            rdy = which ? ready_b : ready_a;
            if (rdy) begin
                lat = k;
                data = which ? data_b : data_a;
                err  = which ? err_b : err_a;
                @(posedge clk); #1;
                rdy_after = which ? ready_b : ready_a;
                break;
            end
        end
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready_a, err_a, data_a} !== '0 || {ready_b, err_b, data_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: a=%b/%b/%h b=%b/%b/%h, required all 0",
                     ready_a, err_a, data_a, ready_b, err_b, data_b);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_line;
        int lat; logic [127:0] d; logic e, ra;
        for (int i = 0; i < 4; i++) write_word(32'h100 + i, 32'hA0 + i);
        do_req(1'b0, 32'h400, 1'b0, lat, d, e, ra);
        checks++;
        if (lat !== 7 || d !== 128'h000000A3_000000A2_000000A1_000000A0 || e !== 1'b0 || ra !== 1'b0) begin
            errors++;
            $display("FAIL basic_line: lat=%0d data=%h err=%b ready_next=%b, required 7/%h/0/0",
                     lat, d, e, ra, 128'h000000A3_000000A2_000000A1_000000A0);
        end
    endtask

    task automatic test_latency_zero;
        int lat; logic [127:0] d; logic e, ra;
        do_req(1'b1, 32'h40C, 1'b0, lat, d, e, ra);
        checks++;
        if (lat !== 4 || d !== model_line(32'h400) || e !== 1'b0 || ra !== 1'b0) begin
            errors++;
            $display("FAIL latency_zero: lat=%0d data=%h err=%b ready_next=%b, required 4/%h/0/0",
                     lat, d, e, ra, model_line(32'h400));
        end
    endtask

    task automatic test_hold;
        int pulses, lat; logic [127:0] d; logic e, ra;
        @(negedge clk);
        req_a = 1'b1; addr_a = 32'h400;
        pulses = 0;
        // 7 cycles to the pulse plus 12 more with the request held
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (ready_a) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL hold_single_pulse: pulses=%0d, required 1", pulses);
        end
        @(negedge clk);
        req_a = 1'b0;
        do_req(1'b0, 32'h400, 1'b0, lat, d, e, ra);
        checks++;
        if (lat !== 7 || d !== model_line(32'h400)) begin
            errors++;
            $display("FAIL hold_rearm: lat=%0d data=%h, required 7/%h", lat, d, model_line(32'h400));
        end
    endtask

    task automatic test_abort;
        int pulses, lat; logic [127:0] d; logic e, ra;
        for (int i = 0; i < 4; i++) write_word(32'h200 + i, $urandom);
        @(negedge clk);
        req_a = 1'b1; addr_a = 32'h400;
        repeat (5) @(posedge clk);     // accept edge plus four: second FETCH beat
        @(negedge clk);
        req_a = 1'b0;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (ready_a) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_ready: pulses=%0d, required 0", pulses);
        end
        do_req(1'b0, 32'h800, 1'b0, lat, d, e, ra);
        checks++;
        if (lat !== 7 || d !== model_line(32'h800) || e !== 1'b0) begin
            errors++;
            $display("FAIL abort_next_req: lat=%0d data=%h err=%b, required 7/%h/0",
                     lat, d, e, model_line(32'h800));
        end
    endtask

    task automatic test_reset_mid;
        int lat, k_seen; logic [127:0] d; logic e, ra;
        // Reset while waiting
        @(negedge clk);
        req_a = 1'b1; addr_a = 32'h400;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_a = 1'b0;
        #1;
        checks++;
        if (ready_a !== 1'b0 || data_a !== '0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait: ready=%b data=%h err=%b, required 0", ready_a, data_a, err_a);
        end
        @(negedge clk);
        rst = 1'b1;
        // Reset while the response is on the bus must clear it without a clock
        @(negedge clk);
        req_a = 1'b1; addr_a = 32'h400;
        k_seen = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (ready_a) begin k_seen = k; break; end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (k_seen < 0 || ready_a !== 1'b0 || data_a !== '0) begin
            errors++;
            $display("FAIL reset_in_resp: seen=%0d ready=%b data=%h, required pulse then 0",
                     k_seen, ready_a, data_a);
        end
        // Held request after release is a fresh request
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        lat = -1; d = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ready_a) begin lat = k; d = data_a; break; end
        end
        @(negedge clk);
        req_a = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (lat !== 7 || d !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            errors++;
            $display("FAIL reset_rerequest: lat=%0d data=%h, required 7/preload", lat, d);
        end
        do_req(1'b0, 32'h400, 1'b0, lat, d, e, ra);
        checks++;
        if (lat !== 7 || d !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            errors++;
            $display("FAIL reset_store_kept: lat=%0d data=%h, required 7/preload", lat, d);
        end
    endtask

    task automatic test_read_before_write;
        int lat; logic [127:0] d, expected; logic e, ra;
        expected = model_line(32'h400);
        @(negedge clk);
        req_a = 1'b1; addr_a = 32'h400;
        lat = -1; d = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            // word 2 is latched at accept+6; write the same word on that edge
            wr_en = (k == 6); wr_addr = 32'h102; wr_data = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            if (ready_a && lat < 0) begin lat = k; d = data_a; end
        end
        @(negedge clk);
        wr_en = 1'b0; req_a = 1'b0;
        model_mem[32'h102] = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        checks++;
        if (lat !== 7 || d !== expected) begin
            errors++;
            $display("FAIL read_before_write: lat=%0d data=%h, required 7/%h", lat, d, expected);
        end
        do_req(1'b0, 32'h400, 1'b0, lat, d, e, ra);
        checks++;
        if (d !== model_line(32'h400) || d[95:64] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_visible: data=%h, required %h", d, model_line(32'h400));
        end
    endtask

    task automatic test_range;
        int lat; logic [127:0] d; logic e, ra;
        for (int i = 0; i < 4; i++) write_word(i, 32'h5000_0000 + i);
        do_req(1'b0, 32'h4000, 1'b0, lat, d, e, ra);
        checks++;
        if (lat !== 7 || d !== model_line(32'h4000) || e !== model_err(32'h4000)) begin
            errors++;
            $display("FAIL range_a: lat=%0d data=%h err=%b, required 7/%h/%b",
                     lat, d, e, model_line(32'h4000), model_err(32'h4000));
        end
        do_req(1'b1, 32'h4000, 1'b0, lat, d, e, ra);
        checks++;
        if (lat !== 4 || d !== model_line(32'h4000) || e !== model_err(32'h4000)) begin
            errors++;
            $display("FAIL range_b: lat=%0d data=%h err=%b, required 4/%h/%b",
                     lat, d, e, model_line(32'h4000), model_err(32'h4000));
        end
    endtask

    task automatic test_random;
        int lat, want; logic [127:0] d; logic e, ra; logic [31:0] addr; bit which;
        for (int it = 0; it < 12; it++) begin
            addr  = {$urandom_range(0, DEPTH / 4 - 1), 4'($urandom)};
            which = 1'($urandom);
            for (int i = 0; i < 4; i++) write_word((addr >> 2) + i - (addr[3:2]), $urandom);
            do_req(which, addr, 1'($urandom), lat, d, e, ra);
            want = which ? 4 : 7;
            checks++;
            if (lat !== want || d !== model_line(addr) || e !== 1'b0 || ra !== 1'b0) begin
                errors++;
                $display("FAIL random[%0d]: dut=%0d addr=%h lat=%0d data=%h err=%b, required %0d/%h/0",
                         it, which, addr, lat, d, e, want, model_line(addr));
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic_line;
        test_latency_zero;
        test_hold;
        test_abort;
        test_reset_mid;
        test_read_before_write;
        test_range;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
